// File: rtl/countdown_pkg.sv
// Shared types and constants for the countdown timer blocks (launcher, countdown, display).
package countdown_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_STOP,
        ERROR
    } launcher_state_t;

    localparam int TIME_W           = 16;
    localparam int MIN_TIME_DEFAULT = 1;
    localparam int MAX_TIME_DEFAULT = 9999;

    // True when every nibble of a 4-digit BCD word is a decimal digit.
    function automatic logic bcd_valid(input logic [TIME_W-1:0] bcd);
        logic ok;
        ok = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (bcd[4*k +: 4] > 4'd9) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

    function automatic logic [TIME_W-1:0] bcd_to_bin(input logic [TIME_W-1:0] bcd);
        return TIME_W'(bcd[15:12]) * TIME_W'(1000)
             + TIME_W'(bcd[11:8])  * TIME_W'(100)
             + TIME_W'(bcd[7:4])   * TIME_W'(10)
             + TIME_W'(bcd[3:0]);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchroniser, stability counter and a one-cycle pulse
// on each debounced rising edge.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync1_reg;
    logic             sync2_reg;
    logic             level_reg;
    logic             press_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             settled;

    // The synchronised level has disagreed with the accepted level long enough.
    assign settled = (sync2_reg != level_reg) && (cnt_reg == CNT_W'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            level_reg <= 1'b0;
            press_reg <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            sync1_reg <= btn_raw;
            sync2_reg <= sync1_reg;
            if ((sync2_reg == level_reg) || settled) begin
                cnt_reg <= '0;
            end else begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
            if (settled) begin
                level_reg <= sync2_reg;
            end
            press_reg <= settled & sync2_reg;
        end
    end

    assign press = press_reg;

endmodule

// File: rtl/countdown_launcher.sv
// Launch control for the countdown timer: debounced confirm, range check, start/stop handshake.
// Optional build macro COUNTDOWN_LAUNCHER_BCD_INPUT_EN: switches carry 4 BCD digits.
module countdown_launcher
    import countdown_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int MIN_TIME        = MIN_TIME_DEFAULT,
    parameter int MAX_TIME        = MAX_TIME_DEFAULT,
    parameter int ERR_HOLD_CYCLES = 50_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [TIME_W-1:0] sw,
    input  logic              btn_confirm,
    input  logic              stop,
    output logic [TIME_W-1:0] time_out,
    output logic              start,
    output logic              busy,
    output logic              err_led
);

    localparam int ERR_W = $clog2(ERR_HOLD_CYCLES + 1);

    launcher_state_t   state_reg;
    launcher_state_t   state_next;
    logic [TIME_W-1:0] time_reg;
    logic [TIME_W-1:0] time_next;
    logic [ERR_W-1:0]  err_cnt_reg;
    logic [ERR_W-1:0]  err_cnt_next;

    logic              press;
    logic [TIME_W-1:0] sw_value;
    logic              sw_format_ok;
    logic              launch_ok;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_raw(btn_confirm),
        .press  (press)
    );

`ifdef COUNTDOWN_LAUNCHER_BCD_INPUT_EN
    assign sw_format_ok = bcd_valid(sw);
    assign sw_value     = bcd_to_bin(sw);
`else
    assign sw_format_ok = 1'b1;
    assign sw_value     = sw;
`endif

    assign launch_ok = sw_format_ok
                    && (sw_value >= TIME_W'(MIN_TIME))
                    && (sw_value <= TIME_W'(MAX_TIME));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            time_reg    <= '0;
            err_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            time_reg    <= time_next;
            err_cnt_reg <= err_cnt_next;
        end
    end

    // Outputs decode straight from the state register, so reset clears them at once.
    always_comb begin
        state_next   = state_reg;
        time_next    = time_reg;
        err_cnt_next = err_cnt_reg;
        start        = 1'b0;
        busy         = 1'b0;
        err_led      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (press) begin
                    if (launch_ok) begin
                        time_next  = sw_value;
                        state_next = LAUNCH;
                    end else begin
                        err_cnt_next = ERR_W'(ERR_HOLD_CYCLES - 1);
                        state_next   = ERROR;
                    end
                end
            end
            LAUNCH: begin
                start      = 1'b1;
                busy       = 1'b1;
                state_next = WAIT_STOP;
            end
            WAIT_STOP: begin
                busy = 1'b1;
                if (stop) begin
                    state_next = IDLE;
                end
            end
            ERROR: begin
                err_led = 1'b1;
                if (err_cnt_reg == '0) begin
                    state_next = IDLE;
                end else begin
                    err_cnt_next = err_cnt_reg - ERR_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign time_out = time_reg;

endmodule

// File: tb/tb_countdown_launcher.sv
// Directed bench for countdown_launcher with a cycle-level reference model and literal spot checks.
module tb_countdown_launcher;

    localparam int DEB  = 4;
    localparam int HOLD = 8;

`ifdef COUNTDOWN_LAUNCHER_BCD_INPUT_EN
    localparam logic [15:0] SW_30  = 16'h0030;
    localparam logic [15:0] SW_1   = 16'h0001;
    localparam logic [15:0] SW_MAX = 16'h9999;
    localparam logic [15:0] SW_BIG = 16'hA000;
`else
    localparam logic [15:0] SW_30  = 16'd30;
    localparam logic [15:0] SW_1   = 16'd1;
    localparam logic [15:0] SW_MAX = 16'd9999;
    localparam logic [15:0] SW_BIG = 16'd10000;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] sw = '0;
    logic        btn_confirm = 1'b0;
    logic        stop = 1'b0;
    logic [15:0] time_out;
    logic        start;
    logic        busy;
    logic        err_led;

    int total = 0;
    int bad   = 0;
    int start_seen = 0;
    int err_seen   = 0;

    countdown_launcher #(
        .DEBOUNCE_CYCLES(DEB),
        .ERR_HOLD_CYCLES(HOLD)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sw         (sw),
        .btn_confirm(btn_confirm),
        .stop       (stop),
        .time_out   (time_out),
        .start      (start),
        .busy       (busy),
        .err_led    (err_led)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    localparam int M_IDLE = 0, M_LAUNCH = 1, M_WAIT = 2, M_ERR = 3;

    int m_hist [DEB+2];     // m_hist[0] = button seen at the previous edge, older further up
    bit m_level = 0;
    bit m_press = 0;
    int m_mode  = M_IDLE;
    int m_left  = 0;
    int m_time  = 0;

    function automatic bit m_accept(input logic [15:0] v, output int val);
`ifdef COUNTDOWN_LAUNCHER_BCD_INPUT_EN
        int dig [4];
        for (int k = 0; k < 4; k++) begin
            dig[k] = (int'(v) >> (4 * k)) % 16;
            if (dig[k] > 9) begin
                val = 0;
                return 0;
            end
        end
        val = dig[3] * 1000 + dig[2] * 100 + dig[1] * 10 + dig[0];
`else
        val = int'(v);
`endif
        return (val >= 1) && (val <= 9999);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEB + 2; i++) m_hist[i] = 0;
            m_level = 0;
            m_press = 0;
            m_mode  = M_IDLE;
            m_left  = 0;
            m_time  = 0;
        end else begin
            int  val;
            bit  flip;
            case (m_mode)
                M_IDLE: if (m_press) begin
                    if (m_accept(sw, val)) begin
                        m_time = val;
                        m_mode = M_LAUNCH;
                    end else begin
                        m_left = HOLD;
                        m_mode = M_ERR;
                    end
                end
                M_LAUNCH: m_mode = M_WAIT;
                M_WAIT:   if (stop) m_mode = M_IDLE;
                default: begin
                    m_left--;
                    if (m_left == 0) m_mode = M_IDLE;
                end
            endcase
            // Accept a new level once the synchronised button has disagreed for DEB straight cycles.
            flip = 1;
            for (int i = 1; i <= DEB; i++) begin
                if (m_hist[i] == int'(m_level)) flip = 0;
            end
            m_press = 0;
            if (flip) begin
                m_level = !m_level;
                m_press = m_level;
            end
            for (int i = DEB + 1; i > 0; i--) m_hist[i] = m_hist[i-1];
            m_hist[0] = int'(btn_confirm);
        end
    end

    always @(negedge clk) begin
        check("start", start, (m_mode == M_LAUNCH));
        check("busy", busy, (m_mode == M_LAUNCH) || (m_mode == M_WAIT));
        check("err_led", err_led, (m_mode == M_ERR));
        check("time_out", time_out, m_time);
        if (start) start_seen++;
        if (err_led) err_seen++;
    end

    // ---------------- stimulus ----------------
    task automatic press_btn(input logic [15:0] v, input int hold, input int after);
        sw = v;
        btn_confirm = 1'b1;
        repeat (hold) @(negedge clk);
        btn_confirm = 1'b0;
        repeat (after) @(negedge clk);
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_start"}, start, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_err"}, err_led, 0);
        check({tag, "_time"}, time_out, 0);
    endtask

    initial begin
        #(200_000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        int e0;
        bit found;

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // normal launch, held button gives a single start
        s0 = start_seen;
        press_btn(SW_30, 20, 10);
        check("launch30_starts", start_seen - s0, 1);
        check("launch30_time", time_out, 30);
        check("launch30_busy", busy, 1);
        repeat (27) @(negedge clk);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("stop_clears_busy", busy, 0);
        $display("step launch 30 then stop: starts=%0d", start_seen - s0);

        // out-of-range values
        s0 = start_seen; e0 = err_seen;
        press_btn(16'd0, 10, 20);
        check("zero_err_cycles", err_seen - e0, 8);
        check("zero_no_start", start_seen - s0, 0);
        check("zero_time_kept", time_out, 30);
        e0 = err_seen;
        press_btn(SW_BIG, 10, 20);
        check("big_err_cycles", err_seen - e0, 8);
        check("big_no_start", start_seen - s0, 0);
        check("big_time_kept", time_out, 30);
        $display("step rejects: err cycles each=8 expected, starts=%0d", start_seen - s0);

        // range boundaries
        s0 = start_seen;
        press_btn(SW_1, 10, 12);
        check("min_time", time_out, 1);
        pulse_stop();
        press_btn(SW_MAX, 10, 12);
        check("max_time", time_out, 9999);
        pulse_stop();
        check("bounds_starts", start_seen - s0, 2);
        $display("step bounds: starts=%0d", start_seen - s0);

        // bouncing contact
        s0 = start_seen;
        sw = SW_30;
        for (int i = 0; i < 10; i++) begin
            btn_confirm = ((i / 2) % 2) == 0;
            @(negedge clk);
        end
        btn_confirm = 1'b1;
        repeat (10) @(negedge clk);
        btn_confirm = 1'b0;
        repeat (10) @(negedge clk);
        check("bounce_starts", start_seen - s0, 1);
        pulse_stop();
        $display("step bounce: starts=%0d", start_seen - s0);

        // presses while busy, and a press landing on the stop cycle
        s0 = start_seen;
        press_btn(SW_30, 10, 10);
        press_btn(SW_1, 10, 10);
        check("busy_press_dropped", start_seen - s0, 1);
        sw = SW_1;
        btn_confirm = 1'b1;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (m_press) found = 1;
        end
        check("press_event_timeout", found, 1);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        repeat (5) @(negedge clk);
        btn_confirm = 1'b0;
        repeat (10) @(negedge clk);
        check("stop_press_dropped", start_seen - s0, 1);
        check("stop_press_time", time_out, 30);
        check("stop_press_idle", busy, 0);
        press_btn(SW_1, 10, 10);
        check("after_idle_launch", start_seen - s0, 2);
        check("after_idle_time", time_out, 1);
        pulse_stop();
        $display("step busy presses: starts=%0d", start_seen - s0);

        // asynchronous reset during WAIT_STOP
        press_btn(SW_30, 10, 10);
        #2 rst_n = 1'b0;
        #1 check_all_zero("rst_wait");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // asynchronous reset during ERROR
        press_btn(16'd0, 9, 0);
        check("err_active", err_led, 1);
        #2 rst_n = 1'b0;
        #1 check_all_zero("rst_err");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        s0 = start_seen;
        press_btn(SW_MAX, 10, 12);
        check("post_reset_launch", start_seen - s0, 1);
        check("post_reset_time", time_out, 9999);
        pulse_stop();
        $display("step resets: post-reset starts=%0d", start_seen - s0);

`ifdef COUNTDOWN_LAUNCHER_BCD_INPUT_EN
        s0 = start_seen; e0 = err_seen;
        press_btn(16'h0125, 10, 12);
        check("bcd_time", time_out, 125);
        pulse_stop();
        press_btn(16'h00A1, 10, 20);
        check("bcd_bad_err", err_seen - e0, 8);
        check("bcd_bad_starts", start_seen - s0, 1);
        check("bcd_bad_time", time_out, 125);
        $display("step bcd: starts=%0d", start_seen - s0);
`endif

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
